// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
// The arbiter connects through the slave modport; the requester side uses master.
interface ring_rr_arbiter_if #(
  parameter int N    = 16,
  parameter int IDXW = 4
) ();
  logic [N-1:0]    REQ;
  logic            DONE;
  logic [N-1:0]    GNT;
  logic [IDXW-1:0] GNT_IDX;
  logic            GNT_VLD;
  logic [N-1:0]    PTR;
  logic            TIMEOUT;

  modport master (
    output REQ, DONE,
    input  GNT, GNT_IDX, GNT_VLD, PTR, TIMEOUT
  );

  modport slave (
    input  REQ, DONE,
    output GNT, GNT_IDX, GNT_VLD, PTR, TIMEOUT
  );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter: a one-hot ring pointer marks the highest-priority requester
// and moves one past each requester when its grant is released.
module ring_rr_arbiter #(
  parameter int N        = 16,
  parameter int IDXW     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  ring_rr_arbiter_if.slave  arb
);

  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [N-1:0]    gnt_q;
  logic [IDXW-1:0] gnt_idx_q;
  logic            gnt_vld_q;
  logic [N-1:0]    ptr_q;
  logic            timeout_q;
  logic [CW-1:0]   hold_q;

  logic [IDXW-1:0] ptr_idx;
  logic [2*N-1:0]  req_dbl;
  logic [N-1:0]    req_rot;
  logic [IDXW-1:0] pick_off;
  logic            pick_vld;
  logic [IDXW:0]   idx_sum;
  logic [IDXW-1:0] pick_idx;
  logic [N-1:0]    gnt_rotl;
  logic            req_held;
  logic            hold_expired;
  logic            release_now;

  always_comb begin
    ptr_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr_q[i]) ptr_idx = IDXW'(i);
    end
  end

  // Rotate requests so the pointer position lands at bit 0, then take the lowest set bit.
  assign req_dbl = {arb.REQ, arb.REQ};
  assign req_rot = N'(req_dbl >> ptr_idx);

  always_comb begin
    pick_vld = 1'b0;
    pick_off = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pick_vld = 1'b1;
        pick_off = IDXW'(k);
      end
    end
    idx_sum = {1'b0, ptr_idx} + {1'b0, pick_off};
    if (idx_sum >= (IDXW+1)'(N)) idx_sum = idx_sum - (IDXW+1)'(N);
    pick_idx = IDXW'(idx_sum);
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_rotl
    assign gnt_rotl[gi] = gnt_q[(gi + N - 1) % N];
  end

  assign req_held     = |(arb.REQ & gnt_q);
  assign hold_expired = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);
  assign release_now  = arb.DONE || !req_held || hold_expired;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= N'(1);
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q   <= GRANT;
            gnt_q     <= N'(1) << pick_idx;
            gnt_idx_q <= pick_idx;
            gnt_vld_q <= 1'b1;
            hold_q    <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= gnt_rotl;
            // Only a pure hold-limit revocation counts as a timeout.
            timeout_q <= !arb.DONE && req_held;
          end else if (hold_q != '1) begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign arb.GNT     = gnt_q;
  assign arb.GNT_IDX = gnt_idx_q;
  assign arb.GNT_VLD = gnt_vld_q;
  assign arb.PTR     = ptr_q;
  assign arb.TIMEOUT = timeout_q;

endmodule
